// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES FIFO sequencer: FSM state encoding,
// block geometry and the default WAIT timeout.
package aes_seq_pkg;

  localparam int unsigned WORDS_PER_BLK   = 4;
  localparam int unsigned WORD_W          = 32;
  localparam int unsigned BLK_W           = WORDS_PER_BLK * WORD_W;
  localparam int unsigned TIMEOUT_CYC_DEF = 256;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GATHER = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

endpackage

// File: rtl/aes_fifo_sequencer.sv
// Sequences 32-bit words from an input FIFO into 128-bit AES blocks, runs the
// core, and drains the ciphertext MSB-first into an output FIFO.
module aes_fifo_sequencer
  import aes_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk_main_a0,
  input  logic               rst_main_n,
  input  logic               enable,
  input  logic               soft_clear,
  input  logic               in_empty,
  output logic               in_rd_en,
  input  logic [WORD_W-1:0]  in_dout,
  input  logic               out_full,
  output logic               out_wr_en,
  output logic [WORD_W-1:0]  out_din,
  output logic               aes_start,
  output logic [BLK_W-1:0]   aes_din,
  input  logic               aes_done,
  input  logic [BLK_W-1:0]   aes_dout,
  output logic [CNT_W-1:0]   blk_cnt,
  output logic               timeout_err,
  output logic [2:0]         state_o
);

  localparam int unsigned WCNT_W = $clog2(WORDS_PER_BLK) + 1;
  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WCNT_W-1:0] WORDS_ALL  = WCNT_W'(WORDS_PER_BLK);
  localparam logic [WCNT_W-1:0] WORDS_LAST = WCNT_W'(WORDS_PER_BLK - 1);
  localparam logic [TCNT_W-1:0] TO_LAST    = TCNT_W'(TIMEOUT_CYC - 1);

  // Reset asserts asynchronously, releases two edges after rst_main_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) rst_sync_q <= 2'b00;
    else             rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   pops_q, pops_d;
  logic [WCNT_W-1:0]   caps_q, caps_d;
  logic [WCNT_W-1:0]   drain_q, drain_d;
  logic                rd_pend_q, rd_pend_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [BLK_W-1:0]    din_q, din_d;
  logic [BLK_W-1:0]    dout_q, dout_d;
  logic [CNT_W-1:0]    blk_cnt_q, blk_cnt_d;
  logic                terr_q, terr_d;

  always_ff @(posedge clk_main_a0 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pops_q    <= '0;
      caps_q    <= '0;
      drain_q   <= '0;
      rd_pend_q <= 1'b0;
      tcnt_q    <= '0;
      din_q     <= '0;
      dout_q    <= '0;
      blk_cnt_q <= '0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pops_q    <= pops_d;
      caps_q    <= caps_d;
      drain_q   <= drain_d;
      rd_pend_q <= rd_pend_d;
      tcnt_q    <= tcnt_d;
      din_q     <= din_d;
      dout_q    <= dout_d;
      blk_cnt_q <= blk_cnt_d;
      terr_q    <= terr_d;
    end
  end

  // Next-state, datapath updates and FIFO/core handshakes.
  always_comb begin
    state_d   = state_q;
    pops_d    = pops_q;
    caps_d    = caps_q;
    drain_d   = drain_q;
    rd_pend_d = 1'b0;
    tcnt_d    = tcnt_q;
    din_d     = din_q;
    dout_d    = dout_q;
    blk_cnt_d = blk_cnt_q;
    terr_d    = terr_q;
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    aes_start = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable && !in_empty) begin
          state_d = ST_GATHER;
          pops_d  = '0;
          caps_d  = '0;
        end
      end

      ST_GATHER: begin
        in_rd_en = !in_empty && (pops_q < WORDS_ALL);
        if (in_rd_en) pops_d = pops_q + WCNT_W'(1);
        // Popped word arrives one cycle later; first word lands in the MSBs.
        if (rd_pend_q) begin
          for (int k = 0; k < int'(WORDS_PER_BLK); k++) begin
            if (caps_q == WCNT_W'(k)) din_d[BLK_W-1-WORD_W*k -: WORD_W] = in_dout;
          end
          caps_d = caps_q + WCNT_W'(1);
          if (caps_q == WORDS_LAST) state_d = ST_START;
        end
      end

      ST_START: begin
        aes_start = 1'b1;
        tcnt_d    = '0;
        state_d   = ST_WAIT;
      end

      ST_WAIT: begin
        if (aes_done) begin
          dout_d  = aes_dout;
          drain_d = '0;
          state_d = ST_DRAIN;
        end else if (tcnt_q == TO_LAST) begin
          terr_d  = 1'b1;
          state_d = ST_ERR;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end

      ST_DRAIN: begin
        out_wr_en = !out_full;
        if (out_wr_en) begin
          drain_d = drain_q + WCNT_W'(1);
          if (drain_q == WORDS_LAST) begin
            blk_cnt_d = blk_cnt_q + CNT_W'(1);
            pops_d    = '0;
            caps_d    = '0;
            state_d   = (enable && !in_empty) ? ST_GATHER : ST_IDLE;
          end
        end
      end

      ST_ERR: begin
        state_d = ST_ERR;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort from any state; the handshakes of this cycle are withheld too.
    if (soft_clear) begin
      state_d   = ST_IDLE;
      pops_d    = '0;
      caps_d    = '0;
      drain_d   = '0;
      tcnt_d    = '0;
      din_d     = '0;
      blk_cnt_d = '0;
      terr_d    = 1'b0;
      in_rd_en  = 1'b0;
      out_wr_en = 1'b0;
      aes_start = 1'b0;
    end

    rd_pend_d = in_rd_en;
  end

  // Ciphertext word selected by the drain index, MSB word first.
  always_comb begin
    out_din = '0;
    for (int k = 0; k < int'(WORDS_PER_BLK); k++) begin
      if (drain_q == WCNT_W'(k)) out_din = dout_q[BLK_W-1-WORD_W*k -: WORD_W];
    end
  end

  assign aes_din     = din_q;
  assign blk_cnt     = blk_cnt_q;
  assign timeout_err = terr_q;
  assign state_o     = 3'(state_q);

endmodule

// File: tb/tb_aes_fifo_sequencer.sv
// Directed bench for aes_fifo_sequencer: FIFO and AES core models driven from a
// table of hand-computed blocks plus scripted timeout, clear and reset cases.
module tb_aes_fifo_sequencer;

  // Narrow block counter so the wrap is reached in 16 blocks.
  localparam int unsigned CNT_W = 4;

  logic               clk_main_a0 = 1'b0;
  logic               rst_main_n, enable, soft_clear, in_empty, in_rd_en;
  logic               out_full, out_wr_en, aes_start, aes_done, timeout_err;
  logic [31:0]        in_dout, out_din;
  logic [127:0]       aes_din, aes_dout;
  logic [CNT_W-1:0]   blk_cnt;
  logic [2:0]         state_o;

  always #5 clk_main_a0 = ~clk_main_a0;

  aes_fifo_sequencer #(.TIMEOUT_CYC(256), .CNT_W(CNT_W)) dut (
    .clk_main_a0(clk_main_a0), .rst_main_n(rst_main_n), .enable(enable),
    .soft_clear(soft_clear), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .in_dout(in_dout), .out_full(out_full), .out_wr_en(out_wr_en),
    .out_din(out_din), .aes_start(aes_start), .aes_din(aes_din),
    .aes_done(aes_done), .aes_dout(aes_dout), .blk_cnt(blk_cnt),
    .timeout_err(timeout_err), .state_o(state_o)
  );

  typedef struct {
    logic [31:0]  w [4];
    logic [127:0] resp;
    int           lat;
    int           gap;
    int           full;
    bit           en_drop;
    logic [127:0] exp_din;
    logic [31:0]  exp_out [4];
  } vec_t;

  vec_t         tab [4];
  logic [31:0]  in_q [$];
  logic [31:0]  got_q [$];
  int           checks, errors, starts, pending, aes_lat, full_hold;
  logic [127:0] aes_resp, din_start, din_done;
  logic [2:0]   st_s;
  logic         rd_s, wr_s, start_s;
  logic [31:0]  nxt;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [31:0] w);
    in_q.push_back(w);
    in_empty = 1'b0;
  endtask

  // One clock: sample outputs mid-cycle, then update FIFO/core models after the edge.
  task automatic cyc();
    @(negedge clk_main_a0);
    st_s = state_o; rd_s = in_rd_en; wr_s = out_wr_en; start_s = aes_start;
    if (start_s) begin
      starts++;
      din_start = aes_din;
      if (aes_lat > 0) pending = aes_lat;
    end
    if (aes_done) din_done = aes_din;
    if (wr_s) got_q.push_back(out_din);
    if (rd_s) nxt = (in_q.size() > 0) ? in_q.pop_front() : 32'hBAD0BAD0;
    @(posedge clk_main_a0);
    #1;
    soft_clear = 1'b0;
    aes_done   = 1'b0;
    aes_dout   = ~aes_resp;
    in_dout    = rd_s ? nxt : 32'h0BADF00D;
    in_empty   = (in_q.size() == 0);
    if (pending > 0) begin
      pending--;
      if (pending == 0) begin
        aes_done = 1'b1;
        aes_dout = aes_resp;
      end
    end
    out_full = (full_hold > 0);
    if (full_hold > 0) full_hold--;
  endtask

  task automatic run_block(input int v, input logic [CNT_W-1:0] exp_blk);
    int n, stall;
    bit late, full_done, dropped;
    n = 0; stall = 0; late = 0; full_done = 0; dropped = 0;
    got_q.delete();
    starts = 0; aes_resp = tab[v].resp; aes_lat = tab[v].lat;
    din_start = '0; din_done = '0;
    enable = 1'b1;
    load(tab[v].w[0]); load(tab[v].w[1]);
    if (tab[v].gap == 0) begin
      load(tab[v].w[2]); load(tab[v].w[3]); late = 1;
    end
    while (got_q.size() < 4 && n < 300) begin
      cyc(); n++;
      if (!late && in_q.size() == 0) begin
        stall++;
        if (stall > tab[v].gap) begin
          chk($sformatf("v%0d_gather_stall_state", v), 128'(state_o), 128'd1);
          load(tab[v].w[2]); load(tab[v].w[3]); late = 1;
        end
      end
      if (!full_done && tab[v].full > 0 && got_q.size() == 2) begin
        out_full = 1'b1; full_hold = tab[v].full - 1; full_done = 1;
      end
      if (tab[v].en_drop && !dropped && starts > 0) begin
        enable = 1'b0; load(32'hFFFFFFFF); dropped = 1;
      end
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL v%0d_block_budget: got %0d pushes expected 4", v, got_q.size());
    end
    chk($sformatf("v%0d_blk_cnt", v), 128'(blk_cnt), 128'(exp_blk));
    cyc(); cyc();
    for (int k = 0; k < 4; k++)
      chk($sformatf("v%0d_word%0d", v, k),
          (k < got_q.size()) ? 128'(got_q[k]) : {128{1'bx}}, 128'(tab[v].exp_out[k]));
    chk($sformatf("v%0d_push_count", v), 128'(got_q.size()), 128'd4);
    chk($sformatf("v%0d_start_pulses", v), 128'(starts), 128'd1);
    chk($sformatf("v%0d_din_at_start", v), din_start, tab[v].exp_din);
    chk($sformatf("v%0d_din_at_done", v), din_done, tab[v].exp_din);
    chk($sformatf("v%0d_state_idle", v), 128'(state_o), 128'd0);
    chk($sformatf("v%0d_timeout_err", v), 128'(timeout_err), 128'd0);
    if (tab[v].en_drop) begin
      chk($sformatf("v%0d_no_pop_when_disabled", v), 128'(in_q.size()), 128'd1);
      in_q.delete(); in_empty = 1'b1;
    end
  endtask

  initial begin
    int n, waitc;
    logic bad;

    tab[0].w = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
    tab[0].resp = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
    tab[0].lat = 1; tab[0].gap = 0; tab[0].full = 0; tab[0].en_drop = 0;
    tab[0].exp_din = 128'h000102030405060708090A0B0C0D0E0F;
    tab[0].exp_out = '{32'h69C4E0D8, 32'h6A7B0430, 32'hD8CDB780, 32'h70B4C55A};

    tab[1].w = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98};
    tab[1].resp = 128'h00112233445566778899AABBCCDDEEFF;
    tab[1].lat = 5; tab[1].gap = 3; tab[1].full = 10; tab[1].en_drop = 0;
    tab[1].exp_din = 128'hDEADBEEF0123456789ABCDEFFEDCBA98;
    tab[1].exp_out = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};

    tab[2].w = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    tab[2].resp = 128'hFFFFFFFF00000000A5A5A5A55A5A5A5A;
    tab[2].lat = 2; tab[2].gap = 0; tab[2].full = 1; tab[2].en_drop = 1;
    tab[2].exp_din = 128'h11111111222222223333333344444444;
    tab[2].exp_out = '{32'hFFFFFFFF, 32'h00000000, 32'hA5A5A5A5, 32'h5A5A5A5A};

    tab[3].w = '{32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
    tab[3].resp = 128'h0123456789ABCDEF0F1E2D3C4B5A6978;
    tab[3].lat = 3; tab[3].gap = 1; tab[3].full = 0; tab[3].en_drop = 0;
    tab[3].exp_din = 128'h55555555666666667777777788888888;
    tab[3].exp_out = '{32'h01234567, 32'h89ABCDEF, 32'h0F1E2D3C, 32'h4B5A6978};

    checks = 0; errors = 0; starts = 0; pending = 0; aes_lat = 0; full_hold = 0;
    aes_resp = '0; din_start = '0; din_done = '0; nxt = '0;
    rst_main_n = 1'b0; enable = 1'b1; soft_clear = 1'b0; in_empty = 1'b0;
    in_dout = 32'h12345678; out_full = 1'b0; aes_done = 1'b1; aes_dout = '1;

    // Reset holds everything quiet even with work offered.
    repeat (3) @(posedge clk_main_a0);
    #1;
    chk("rst_state", 128'(state_o), 128'd0);
    chk("rst_rd_en", 128'(in_rd_en), 128'd0);
    chk("rst_wr_en", 128'(out_wr_en), 128'd0);
    chk("rst_start", 128'(aes_start), 128'd0);
    chk("rst_aes_din", aes_din, 128'd0);
    chk("rst_out_din", 128'(out_din), 128'd0);
    chk("rst_blk_cnt", 128'(blk_cnt), 128'd0);
    chk("rst_timeout_err", 128'(timeout_err), 128'd0);
    enable = 1'b0; in_empty = 1'b1; aes_done = 1'b0;
    rst_main_n = 1'b1;
    repeat (3) cyc();
    chk("post_rst_state", 128'(state_o), 128'd0);

    for (int v = 0; v < 4; v++) run_block(v, CNT_W'(v + 1));

    // aes_done outside WAIT must do nothing.
    got_q.delete();
    aes_done = 1'b1; aes_dout = 128'hCAFEF00DCAFEF00DCAFEF00DCAFEF00D;
    repeat (4) cyc();
    chk("stray_done_state", 128'(state_o), 128'd0);
    chk("stray_done_pushes", 128'(got_q.size()), 128'd0);
    chk("stray_done_blk", 128'(blk_cnt), 128'd4);

    // Core never answers: exactly 256 WAIT cycles, then sticky ERR.
    starts = 0; aes_lat = 0; enable = 1'b1;
    for (int k = 0; k < 4; k++) load(tab[0].w[k]);
    n = 0; waitc = 0;
    while (state_o != 3'd5 && n < 600) begin
      cyc(); n++;
      if (st_s == 3'd3) waitc++;
    end
    chk("to_wait_cycles", 128'(waitc), 128'd256);
    chk("to_state_err", 128'(state_o), 128'd5);
    chk("to_flag", 128'(timeout_err), 128'd1);
    chk("to_start_pulses", 128'(starts), 128'd1);
    load(32'hA0A0A0A0); load(32'hB0B0B0B0);
    bad = 1'b0;
    repeat (3) begin
      cyc();
      bad = bad | rd_s | wr_s | start_s;
    end
    chk("err_hold_quiet", 128'(bad), 128'd0);
    chk("err_hold_state", 128'(state_o), 128'd5);
    soft_clear = 1'b1; enable = 1'b0;
    cyc();
    chk("clr_err_state", 128'(state_o), 128'd0);
    chk("clr_err_flag", 128'(timeout_err), 128'd0);
    chk("clr_err_blk", 128'(blk_cnt), 128'd0);
    in_q.delete(); in_empty = 1'b1;

    // Abort after two words; the next block must be built from fresh words only.
    enable = 1'b1; load(32'hAAAAAAAA); load(32'hBBBBBBBB);
    n = 0;
    while (in_q.size() > 0 && n < 20) begin cyc(); n++; end
    cyc(); cyc();
    chk("partial_state", 128'(state_o), 128'd1);
    load(32'hCCCCCCCC); soft_clear = 1'b1; enable = 1'b0;
    cyc();
    chk("clr_pop_suppressed", 128'(rd_s), 128'd0);
    chk("clr_partial_state", 128'(state_o), 128'd0);
    in_q.delete(); in_empty = 1'b1;
    run_block(3, CNT_W'(1));

    // Asynchronous reset in the middle of DRAIN.
    starts = 0; aes_resp = tab[0].resp; aes_lat = 1; enable = 1'b1;
    for (int k = 0; k < 4; k++) load(tab[0].w[k]);
    n = 0;
    while (state_o != 3'd4 && n < 50) begin cyc(); n++; end
    chk("pre_arst_state", 128'(state_o), 128'd4);
    #2;
    rst_main_n = 1'b0;
    #1;
    chk("arst_state", 128'(state_o), 128'd0);
    chk("arst_blk_cnt", 128'(blk_cnt), 128'd0);
    chk("arst_aes_din", aes_din, 128'd0);
    chk("arst_out_din", 128'(out_din), 128'd0);
    chk("arst_wr_en", 128'(out_wr_en), 128'd0);
    in_q.delete(); in_empty = 1'b1; enable = 1'b0; pending = 0;
    out_full = 1'b0; full_hold = 0; aes_done = 1'b0;
    @(posedge clk_main_a0);
    #1;
    rst_main_n = 1'b1;
    repeat (3) cyc();

    // Sixteen blocks wrap the 4-bit counter back to zero.
    for (int i = 0; i < 16; i++) run_block(i % 4, CNT_W'((i + 1) % 16));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_fifo_sequencer.md
AES_FIFO_SEQUENCER -- requirements
Module: aes_fifo_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 256, max cycles in WAIT before error.
REQ-002 SHALL have parameter CNT_W, default 16, width of the completed-block counter.
REQ-003 SHALL have port clk_main_a0  in  1  clock; all logic on its rising edge.
REQ-004 SHALL have port rst_main_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  in  1  allows new blocks to start.
REQ-006 SHALL have port soft_clear  in  1  one-cycle pulse; abort and clear status.
REQ-007 SHALL have port in_empty  in  1  input FIFO empty.
REQ-008 SHALL have port in_rd_en  out  1  input FIFO pop; data valid the next cycle.
REQ-009 SHALL have port in_dout  in  32  input FIFO read data.
REQ-010 SHALL have port out_full  in  1  output FIFO full.
REQ-011 SHALL have port out_wr_en  out  1  output FIFO push.
REQ-012 SHALL have port out_din  out  32  output FIFO write data.
REQ-013 SHALL have port aes_start  out  1  one-cycle start pulse to the AES core.
REQ-014 SHALL have port aes_din  out  128  assembled plaintext block.
REQ-015 SHALL have port aes_done  in  1  one-cycle pulse; aes_dout valid that cycle.
REQ-016 SHALL have port aes_dout  in  128  ciphertext block.
REQ-017 SHALL have port blk_cnt  out  CNT_W  completed blocks, wrapping.
REQ-018 SHALL have port timeout_err  out  1  sticky timeout flag.
REQ-019 SHALL have port state_o  out  3  current FSM state encoding.

Function
REQ-020 SHALL implement states IDLE, GATHER, START, WAIT, DRAIN, ERR.
REQ-021 IDLE->GATHER SHALL occur when enable=1 and in_empty=0.
REQ-022 In GATHER, in_rd_en SHALL equal ~in_empty while fewer than 4 pops have been issued this block, with at most one pop per cycle.
REQ-023 Each word SHALL be captured one cycle after its pop; word k (0..3) goes to aes_din[127-32k -: 32], so the first word is the MSBs.
REQ-024 GATHER->START SHALL occur in the cycle after the fourth word is captured; START lasts one cycle, with aes_start=1 and aes_din stable.
REQ-025 START->WAIT SHALL be unconditional; aes_din SHALL remain stable through WAIT.
REQ-026 In WAIT, aes_done=1 SHALL latch aes_dout and move to DRAIN.
REQ-027 In WAIT, if TIMEOUT_CYC cycles elapse without aes_done, the FSM SHALL go to ERR and set timeout_err.
REQ-028 In DRAIN, out_wr_en SHALL equal ~out_full; words SHALL be pushed MSB-first (aes_dout[127:96] first), and a word SHALL advance only when pushed.
REQ-029 After the fourth push, blk_cnt SHALL increment modulo 2^CNT_W; the FSM goes to GATHER if enable=1 and in_empty=0, else to IDLE.
REQ-030 Deasserting enable mid-block SHALL NOT abort the block; the block completes and the FSM then returns to IDLE.
REQ-031 ERR SHALL hold with no pops, pushes or starts until soft_clear.
REQ-032 soft_clear in any state SHALL, on the next edge: go to IDLE, discard partial words, clear timeout_err and blk_cnt, and suppress in_rd_en, out_wr_en and aes_start in that cycle.
REQ-033 aes_done outside WAIT SHALL be ignored.
REQ-034 in_empty rising during GATHER SHALL stall without losing captured words.
REQ-035 state_o SHALL use the encoding IDLE=0, GATHER=1, START=2, WAIT=3, DRAIN=4, ERR=5.

Reset
REQ-036 Asserting rst_main_n low SHALL asynchronously force IDLE, counters 0, timeout_err=0, and all data registers 0.
REQ-037 During reset, outputs SHALL be: in_rd_en=0, out_wr_en=0, aes_start=0, aes_din=0, out_din=0, blk_cnt=0, state_o=0.
REQ-038 Reset deassertion SHALL be synchronized internally with a 2-flop synchronizer before use.

Structure
REQ-039 Package aes_seq_pkg SHALL hold the state enum, the constant WORDS_PER_BLK=4, and the default TIMEOUT_CYC.
REQ-040 The block SHALL be a single module with no sub-modules; the timeout counter shares the word counter's width rules and is log2(TIMEOUT_CYC)+1 bits.

Verification
REQ-041 Scenario: enable=1, then push 00010203, 04050607, 08090A0B, 0C0D0E0F -> aes_din=000102030405060708090A0B0C0D0E0F and exactly one aes_start pulse.
REQ-042 Scenario: aes_done returns 69C4E0D86A7B0430D8CDB78070B4C55A -> out_din sequence 69C4E0D8, 6A7B0430, D8CDB780, 70B4C55A, then blk_cnt=1.
REQ-043 Scenario: out_full held for 10 cycles mid-DRAIN -> no word is lost or duplicated, and the output order is preserved.
REQ-044 Scenario: aes_done is never returned -> after 256 WAIT cycles, state_o=5 and timeout_err=1; then soft_clear -> state_o=0 and timeout_err=0.
REQ-045 Scenario: soft_clear after 2 words are gathered -> next block takes 4 fresh words, and aes_din contains no stale data.
REQ-046 Scenario: blk_cnt preloaded by running 65536 blocks -> blk_cnt wraps to 0, with no other side effect.
